// File: rtl/usr_shift_ctrl_if.sv
// Bundle of command, response and usr-facing signals for usr_shift_ctrl.
// The slave modport is the controller; master is the host plus usr side.
interface usr_shift_ctrl_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [CNT_W-1:0] cmd_count;
  logic             cmd_fill;
  logic [1:0]       usr_select;
  logic [WIDTH-1:0] usr_p_din;
  logic             usr_s_left_din;
  logic             usr_s_right_din;
  logic [WIDTH-1:0] usr_p_dout;
  logic             rsp_valid;
  logic [WIDTH-1:0] rsp_data;
  logic             busy;

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, cmd_count, cmd_fill, usr_p_dout,
    output cmd_ready, usr_select, usr_p_din, usr_s_left_din, usr_s_right_din,
           rsp_valid, rsp_data, busy
  );

  modport master (
    output cmd_valid, cmd_op, cmd_data, cmd_count, cmd_fill, usr_p_dout,
    input  cmd_ready, usr_select, usr_p_din, usr_s_left_din, usr_s_right_din,
           rsp_valid, rsp_data, busy
  );
endinterface

// File: rtl/usr_shift_ctrl.sv
// Command sequencer for a universal shift register: accepts one LOAD/SHR/SHL/ROR
// command per handshake, steps the usr select and serial inputs cycle by cycle,
// and reports the resulting register value with a one-cycle response pulse.
module usr_shift_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  usr_shift_ctrl_if.slave bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_SHR  = 2'b01;
  localparam logic [1:0] OP_SHL  = 2'b10;
  localparam logic [1:0] OP_ROR  = 2'b11;

  localparam logic [1:0] SEL_HOLD  = 2'b00;
  localparam logic [1:0] SEL_RIGHT = 2'b01;
  localparam logic [1:0] SEL_LEFT  = 2'b10;
  localparam logic [1:0] SEL_LOAD  = 2'b11;

  logic [1:0]       state;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] data_q;
  logic [CNT_W-1:0] rem_q;
  logic             fill_q;

  // State sequencing and command latch; fields captured on accept stay fixed
  // until the command completes, so host-side changes mid-command are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      op_q   <= OP_LOAD;
      data_q <= '0;
      rem_q  <= '0;
      fill_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            op_q   <= bus.cmd_op;
            data_q <= bus.cmd_data;
            rem_q  <= bus.cmd_count;
            fill_q <= bus.cmd_fill;
            if (bus.cmd_op == OP_LOAD)
              state <= ST_LOAD;
            else if (bus.cmd_count != '0)
              state <= ST_SHIFT;
            else
              state <= ST_DONE;
          end
        end
        ST_LOAD: begin
          state <= ST_DONE;
        end
        ST_SHIFT: begin
          rem_q <= rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1))
            state <= ST_DONE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // usr drive and handshake outputs decoded from the current state; usr holds
  // (select 00) everywhere except the LOAD and SHIFT states.
  always_comb begin
    bus.usr_select      = SEL_HOLD;
    bus.usr_p_din       = '0;
    bus.usr_s_left_din  = 1'b0;
    bus.usr_s_right_din = 1'b0;
    bus.rsp_valid       = 1'b0;
    bus.rsp_data        = '0;
    case (state)
      ST_LOAD: begin
        bus.usr_select = SEL_LOAD;
        bus.usr_p_din  = data_q;
      end
      ST_SHIFT: begin
        case (op_q)
          OP_SHL: begin
            bus.usr_select     = SEL_LEFT;
            bus.usr_s_left_din = fill_q;
          end
          OP_ROR: begin
            bus.usr_select      = SEL_RIGHT;
            bus.usr_s_right_din = bus.usr_p_dout[0];
          end
          default: begin
            bus.usr_select      = SEL_RIGHT;
            bus.usr_s_right_din = fill_q;
          end
        endcase
      end
      ST_DONE: begin
        bus.rsp_valid = 1'b1;
        bus.rsp_data  = bus.usr_p_dout;
      end
      default: begin
      end
    endcase
  end

  assign bus.cmd_ready = (state == ST_IDLE);
  assign bus.busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_usr_shift_ctrl.sv
// Self-checking bench for usr_shift_ctrl with a behavioural usr model behind it.
module tb_usr_shift_ctrl;

  localparam int WIDTH = 4;
  localparam int CNT_W = 3;

  typedef struct {
    logic [1:0] op;
    logic [3:0] data;
    logic [2:0] count;
    logic       fill;
    logic [3:0] exp_rsp;
    int         exp_lat;
  } vec_t;

  logic clk;
  logic rst_n;
  logic [WIDTH-1:0] usr_q;
  int n_pass;
  int n_total;
  vec_t vecs[17];

  usr_shift_ctrl_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  usr_shift_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural universal shift register driven by the controller
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      usr_q <= '0;
    else begin
      case (bus.usr_select)
        2'b01:   usr_q <= {bus.usr_s_right_din, usr_q[WIDTH-1:1]};
        2'b10:   usr_q <= {usr_q[WIDTH-2:0], bus.usr_s_left_din};
        2'b11:   usr_q <= bus.usr_p_din;
        default: usr_q <= usr_q;
      endcase
    end
  end

  assign bus.usr_p_dout = usr_q;

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp)
      n_pass++;
    else
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Issue one command, hold cmd_valid high with scrambled fields while busy,
  // and verify per-cycle drive, latency, response and the return to idle.
  task automatic apply_stimulus(input vec_t v, input string tag);
    int cyc;
    int wait_cyc;
    int shift_cyc;
    int load_cyc;
    int drive_err;
    bit got_rsp;
    logic [3:0] rsp;
    logic exp_sr;
    logic exp_sl;
    logic [1:0] exp_sel;
    wait_cyc = 0;
    while (bus.cmd_ready !== 1'b1 && wait_cyc < 20) begin
      @(posedge clk); #1;
      wait_cyc++;
    end
    check_output({tag, ".ready"}, 32'(bus.cmd_ready), 32'd1);
    bus.cmd_op    = v.op;
    bus.cmd_data  = v.data;
    bus.cmd_count = v.count;
    bus.cmd_fill  = v.fill;
    bus.cmd_valid = 1'b1;
    cyc = 0; shift_cyc = 0; load_cyc = 0; drive_err = 0; got_rsp = 0; rsp = '0;
    exp_sel = (v.op == 2'b10) ? 2'b10 : 2'b01;
    while (!got_rsp && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      if (bus.rsp_valid === 1'b1) begin
        got_rsp = 1;
        rsp = bus.rsp_data;
        if (bus.usr_select !== 2'b00) drive_err++;
      end else begin
        case (bus.usr_select)
          2'b11: begin
            load_cyc++;
            if (bus.usr_p_din !== v.data) drive_err++;
          end
          2'b01, 2'b10: begin
            shift_cyc++;
            if (bus.usr_select !== exp_sel) drive_err++;
            exp_sr = (v.op == 2'b01) ? v.fill : (v.op == 2'b11) ? usr_q[0] : 1'b0;
            exp_sl = (v.op == 2'b10) ? v.fill : 1'b0;
            if (bus.usr_s_right_din !== exp_sr || bus.usr_s_left_din !== exp_sl) drive_err++;
          end
          default: drive_err++;
        endcase
        if (bus.cmd_ready !== 1'b0) drive_err++;
        bus.cmd_op    = 2'($urandom);
        bus.cmd_data  = 4'($urandom);
        bus.cmd_count = 3'($urandom);
        bus.cmd_fill  = 1'($urandom);
      end
    end
    bus.cmd_valid = 1'b0;
    check_output({tag, ".rsp_seen"}, 32'(got_rsp), 32'd1);
    check_output({tag, ".latency"}, 32'(cyc), 32'(v.exp_lat));
    check_output({tag, ".rsp_data"}, 32'(rsp), 32'(v.exp_rsp));
    check_output({tag, ".shift_cycles"}, 32'(shift_cyc), (v.op == 2'b00) ? 32'd0 : 32'(v.count));
    check_output({tag, ".load_cycles"}, 32'(load_cyc), (v.op == 2'b00) ? 32'd1 : 32'd0);
    check_output({tag, ".drive"}, 32'(drive_err), 32'd0);
    @(posedge clk); #1;
    check_output({tag, ".single_rsp"}, 32'(bus.rsp_valid), 32'd0);
    check_output({tag, ".idle_ready"}, 32'(bus.cmd_ready), 32'd1);
  endtask

  initial begin
    int pulses;
    vec_t v;
    n_pass = 0;
    n_total = 0;

    //           op     data   cnt   fill  exp    lat
    vecs[0]  = '{2'b00, 4'hd, 3'd0, 1'b0, 4'hd, 2};
    vecs[1]  = '{2'b01, 4'h0, 3'd2, 1'b1, 4'hf, 3};
    vecs[2]  = '{2'b00, 4'hd, 3'd0, 1'b0, 4'hd, 2};
    vecs[3]  = '{2'b10, 4'h0, 3'd3, 1'b0, 4'h8, 4};
    vecs[4]  = '{2'b00, 4'hd, 3'd0, 1'b0, 4'hd, 2};
    vecs[5]  = '{2'b11, 4'h0, 3'd1, 1'b0, 4'he, 2};
    vecs[6]  = '{2'b00, 4'hd, 3'd0, 1'b0, 4'hd, 2};
    vecs[7]  = '{2'b11, 4'h0, 3'd4, 1'b1, 4'hd, 5};
    vecs[8]  = '{2'b00, 4'hd, 3'd0, 1'b0, 4'hd, 2};
    vecs[9]  = '{2'b11, 4'h0, 3'd7, 1'b0, 4'hb, 8};
    vecs[10] = '{2'b01, 4'h0, 3'd0, 1'b1, 4'hb, 1};
    vecs[11] = '{2'b01, 4'h0, 3'd7, 1'b0, 4'h0, 8};
    vecs[12] = '{2'b10, 4'h0, 3'd5, 1'b1, 4'hf, 6};
    vecs[13] = '{2'b11, 4'h0, 3'd0, 1'b0, 4'hf, 1};
    vecs[14] = '{2'b00, 4'h5, 3'd0, 1'b0, 4'h5, 2};
    vecs[15] = '{2'b10, 4'h0, 3'd1, 1'b1, 4'hb, 2};
    vecs[16] = '{2'b01, 4'h0, 3'd1, 1'b0, 4'h5, 2};

    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_data  = '0;
    bus.cmd_count = '0;
    bus.cmd_fill  = 1'b0;
    rst_n = 1'b0;
    #2;
    check_output("reset.select", 32'(bus.usr_select), 32'd0);
    check_output("reset.p_din", 32'(bus.usr_p_din), 32'd0);
    check_output("reset.serial", 32'({bus.usr_s_left_din, bus.usr_s_right_din}), 32'd0);
    check_output("reset.rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_output("reset.rsp_data", 32'(bus.rsp_data), 32'd0);
    check_output("reset.ready", 32'(bus.cmd_ready), 32'd1);
    check_output("reset.busy", 32'(bus.busy), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 17; i++)
      apply_stimulus(vecs[i], $sformatf("vec%0d", i));

    // Reset in the middle of an SHL N=5 command
    bus.cmd_op    = 2'b10;
    bus.cmd_data  = 4'h0;
    bus.cmd_count = 3'd5;
    bus.cmd_fill  = 1'b1;
    bus.cmd_valid = 1'b1;
    @(posedge clk); #1;
    check_output("rst_mid.pre_select", 32'(bus.usr_select), 32'd2);
    @(posedge clk); #1;
    rst_n = 1'b0;
    bus.cmd_valid = 1'b0;
    #1;
    check_output("rst_mid.select", 32'(bus.usr_select), 32'd0);
    check_output("rst_mid.ready", 32'(bus.cmd_ready), 32'd1);
    check_output("rst_mid.rsp_valid", 32'(bus.rsp_valid), 32'd0);
    pulses = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (bus.rsp_valid === 1'b1) pulses++;
    end
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (bus.rsp_valid === 1'b1) pulses++;
    end
    check_output("rst_mid.no_rsp", 32'(pulses), 32'd0);
    v = '{2'b00, 4'h6, 3'd0, 1'b0, 4'h6, 2};
    apply_stimulus(v, "post_rst_load");

    $display("[TB] %0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
